// File: rtl/painel_scan_ctrl_pkg.sv
// Shared definitions for the 5x7 LED panel sequencer.
// Mode codes, FSM state encodings, panel geometry and a small mode helper.
package painel_defs;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_OFF  = 2'b00,
    ST_LOAD = 2'b01,
    ST_SCAN = 2'b10
  } state_t;

  localparam int NUM_COLS = 7;
  localparam int NUM_ROWS = 5;

  function automatic logic is_shift(input logic [1:0] m);
    return (m == MODE_SHR) || (m == MODE_SHL);
  endfunction

endpackage

// File: rtl/painel_scan_ctrl_sync2.sv
// Two-flop synchronizer for one raw asynchronous switch bit.
// Ports: clk, rst (sync, active-high), d (raw in), q (synchronized out).
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/painel_scan_ctrl.sv
// Panel sequencer: column scan with dead-time blanking plus frame-aligned
// register mode/strobe. Ports: clk, rst, ch0/ch1 raw switches; col_sel,
// col_en scan drive; reg_mode, reg_tick register control; frame_done pulse.
module painel_scan_ctrl #(
  parameter int DIV_SCAN      = 2500,
  parameter int BLANK_CYC     = 250,
  parameter int SCROLL_FRAMES = 20,
  parameter int NUM_COLS      = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ch0,
  input  logic                ch1,
  output logic [2:0]          col_sel,
  output logic [NUM_COLS-1:0] col_en,
  output logic [1:0]          reg_mode,
  output logic                reg_tick,
  output logic                frame_done
);

  import painel_defs::*;

  localparam int SW = (DIV_SCAN > 1) ? $clog2(DIV_SCAN) : 1;
  localparam int FW = $clog2(SCROLL_FRAMES + 1);

  localparam logic [SW-1:0] SLOT_LAST = SW'(DIV_SCAN - 1);
  localparam logic [SW-1:0] LIT_END   = SW'(DIV_SCAN - BLANK_CYC);
  localparam logic [FW-1:0] FRM_LAST  = FW'(SCROLL_FRAMES - 1);
  localparam logic [2:0]    COL_LAST  = 3'(NUM_COLS - 1);

  logic          sw0;
  logic          sw1;
  logic [1:0]    sw;
  state_t        state;
  logic [SW-1:0] slot;
  logic [2:0]    col;
  logic [FW-1:0] frame;
  logic [1:0]    mode;

  logic slot_last;
  logic frame_end;
  logic lit;

  sync2 u_sync0 (
    .clk (clk),
    .rst (rst),
    .d   (ch0),
    .q   (sw0)
  );

  sync2 u_sync1 (
    .clk (clk),
    .rst (rst),
    .d   (ch1),
    .q   (sw1)
  );

  assign sw        = {sw1, sw0};
  assign slot_last = (slot == SLOT_LAST);
  assign frame_end = (state == ST_SCAN) && slot_last
                   && (col == COL_LAST);
  assign lit       = (state == ST_SCAN) && (slot < LIT_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_OFF;
      slot  <= '0;
      col   <= '0;
      frame <= '0;
      mode  <= MODE_HOLD;
    end else begin
      unique case (state)
        ST_OFF: begin
          slot  <= '0;
          col   <= '0;
          frame <= '0;
          mode  <= sw;
          if (sw == MODE_LOAD)
            state <= ST_LOAD;
          else if (sw != MODE_HOLD)
            state <= ST_SCAN;
        end
        ST_LOAD: begin
          mode  <= MODE_LOAD;
          state <= ST_SCAN;
        end
        ST_SCAN: begin
          if (slot_last) begin
            slot <= '0;
            col  <= (col == COL_LAST) ? 3'd0 : col + 3'd1;
          end else begin
            slot <= slot + SW'(1);
          end
          // Mode is only ever re-sampled here, so registers
          // never change mode mid-frame.
          if (frame_end) begin
            if (sw == MODE_HOLD) begin
              state <= ST_OFF;
              mode  <= MODE_HOLD;
              frame <= '0;
            end else if (sw == MODE_LOAD && mode != MODE_LOAD) begin
              state <= ST_LOAD;
              mode  <= MODE_LOAD;
              frame <= '0;
            end else if (sw != mode) begin
              mode  <= sw;
              frame <= '0;
            end else begin
              frame <= (frame == FRM_LAST) ? '0 : frame + FW'(1);
            end
          end
        end
        default: state <= ST_OFF;
      endcase
    end
  end

  assign col_sel    = col;
  assign frame_done = frame_end;

  always_comb begin
    col_en   = '0;
    reg_mode = MODE_HOLD;
    reg_tick = 1'b0;
    unique case (state)
      ST_LOAD: begin
        reg_mode = MODE_LOAD;
        reg_tick = 1'b1;
      end
      ST_SCAN: begin
        reg_mode = mode;
        if (lit)
          col_en = NUM_COLS'(1) << col;
        // Shift strobe lands on the blanked frame_done cycle
        // and only when the mode is not changing there.
        reg_tick = frame_end && (sw == mode)
                 && (frame == FRM_LAST) && is_shift(mode);
      end
      default: begin
        col_en   = '0;
        reg_mode = MODE_HOLD;
        reg_tick = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_painel_scan_ctrl.sv
// Testbench for painel_scan_ctrl: frame-position reference model,
// directed scenarios and randomized switch activity.
module tb_painel_scan_ctrl;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
  localparam int SF    = 2;
  localparam int NC    = 7;
  localparam int FRAME = NC * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ch0 = 1'b1;
  logic       ch1 = 1'b0;
  logic [2:0] col_sel;
  logic [6:0] col_en;
  logic [1:0] reg_mode;
  logic       reg_tick;
  logic       frame_done;

  int tests = 0;
  int fails = 0;

  painel_scan_ctrl #(
    .DIV_SCAN      (DIV),
    .BLANK_CYC     (BLANK),
    .SCROLL_FRAMES (SF),
    .NUM_COLS      (NC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ch0        (ch0),
    .ch1        (ch1),
    .col_sel    (col_sel),
    .col_en     (col_en),
    .reg_mode   (reg_mode),
    .reg_tick   (reg_tick),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  wire [13:0] obs = {col_sel, col_en, reg_mode, reg_tick, frame_done};

  // Reference: mst 0=off 1=load 2=scan; m_pos = cycle within frame.
  int         m_st = 0;
  int         m_pos = 0;
  int         m_fc = 0;
  logic [1:0] m_mode = 2'b00;
  logic [1:0] s1 = 2'b00;
  logic [1:0] s2 = 2'b00;

  function automatic logic [13:0] expv();
    int   c, s;
    logic scan, fd, tick;
    logic [1:0] rm;
    logic [6:0] ce;
    logic [6:0] one;
    c    = m_pos / DIV;
    s    = m_pos % DIV;
    scan = (m_st == 2);
    fd   = scan && (m_pos == FRAME - 1);
    tick = (m_st == 1) || (fd && s2 == m_mode && m_fc == SF - 1
           && (m_mode == 2'b01 || m_mode == 2'b10));
    rm   = (m_st == 0) ? 2'b00 : (m_st == 1) ? 2'b11 : m_mode;
    one  = 7'b1;
    ce   = (scan && s < DIV - BLANK) ? (one << c) : 7'b0;
    return {3'(c), ce, rm, tick, fd};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      s1 <= 0; s2 <= 0; m_st <= 0;
      m_pos <= 0; m_fc <= 0; m_mode <= 0;
    end else begin
      s1 <= {ch1, ch0};
      s2 <= s1;
      case (m_st)
        0: begin
          m_pos <= 0; m_fc <= 0; m_mode <= s2;
          if (s2 == 2'b11) m_st <= 1;
          else if (s2 != 2'b00) m_st <= 2;
        end
        1: begin m_st <= 2; m_mode <= 2'b11; end
        default: begin
          if (m_pos == FRAME - 1) begin
            m_pos <= 0;
            if (s2 == 2'b00) begin
              m_st <= 0; m_mode <= 0; m_fc <= 0;
            end else if (s2 == 2'b11 && m_mode != 2'b11) begin
              m_st <= 1; m_mode <= 2'b11; m_fc <= 0;
            end else if (s2 != m_mode) begin
              m_mode <= s2; m_fc <= 0;
            end else begin
              m_fc <= (m_fc + 1) % SF;
            end
          end else begin
            m_pos <= m_pos + 1;
          end
        end
      endcase
    end
  end

  task automatic test_reset();
    int k;
    logic [6:0] seq [4];
    seq[0] = 7'b0000001; seq[1] = 7'b0000001;
    seq[2] = 7'b0000000; seq[3] = 7'b0000010;
    rst = 1'b1; {ch1, ch0} = 2'b01;
    repeat (3) begin
      @(negedge clk);
      tests++;
      if (obs !== 14'h0) begin
        fails++;
        $display("FAIL reset_outputs got %h exp 0", obs);
      end
    end
    rst = 1'b0;
    k = 0;
    while (k < 6) begin
      @(negedge clk);
      k++;
      tests++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL reset_model got %h exp %h", obs, expv());
      end
      if (col_en !== 7'b0) break;
    end
    tests++;
    if (k > 3 || col_en !== 7'b0000001) begin
      fails++;
      $display("FAIL reset_start got k=%0d en=%b exp k<=3 en=0000001", k, col_en);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if (col_en !== seq[i]) begin
        fails++;
        $display("FAIL reset_seq%0d got %b exp %b", i, col_en, seq[i]);
      end
    end
  endtask

  task automatic test_steady();
    int nfd = 0, ntk = 0, last = -1;
    for (int t = 0; t < 6 * FRAME; t++) begin
      @(negedge clk);
      tests++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL steady_model got %h exp %h", obs, expv());
      end
      if (frame_done === 1'b1) begin
        if (last >= 0) begin
          tests++;
          if (t - last != FRAME) begin
            fails++;
            $display("FAIL steady_period got %0d exp %0d", t - last, FRAME);
          end
        end
        last = t;
        nfd++;
      end
      if (reg_tick === 1'b1) begin
        ntk++;
        tests++;
        if (col_en !== 7'b0 || reg_mode !== 2'b01 || frame_done !== 1'b1) begin
          fails++;
          $display("FAIL steady_tick got en=%b mode=%b fd=%b exp 0/01/1", col_en, reg_mode, frame_done);
        end
      end
    end
    tests++;
    if (nfd != 6 || ntk != 3) begin
      fails++;
      $display("FAIL steady_counts got fd=%0d tick=%0d exp 6/3", nfd, ntk);
    end
  endtask

  task automatic test_mode_change();
    int k = 0, seen = 0, tk = -1, fdt = -1;
    while (!(m_st == 2 && m_pos == 3 * DIV + 1) && k < 3 * FRAME) begin
      @(negedge clk); k++;
    end
    {ch1, ch0} = 2'b10;
    for (int t = 0; t < 4 * FRAME; t++) begin
      @(negedge clk);
      tests++;
      if (obs !== expv() || reg_mode !== (fdt < 0 ? 2'b01 : 2'b10)) begin
        fails++;
        $display("FAIL mode_change got %h exp %h", obs, expv());
      end
      if (frame_done === 1'b1 && fdt < 0) fdt = t;
      if (reg_tick === 1'b1 && tk < 0) tk = t;
    end
    tests++;
    if (fdt < 0 || tk - fdt != 2 * FRAME) begin
      fails++;
      $display("FAIL mode_tick_gap got %0d exp %0d", tk - fdt, 2 * FRAME);
    end
  endtask

  task automatic test_load();
    int k = 0, ntk = 0;
    {ch1, ch0} = 2'b00;
    while (m_st != 0 && k < 2 * FRAME) begin
      @(negedge clk); k++;
    end
    {ch1, ch0} = 2'b11;
    for (int t = 0; t < 10 * FRAME + 8; t++) begin
      @(negedge clk);
      tests++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL load_model got %h exp %h", obs, expv());
      end
      if (reg_tick === 1'b1) begin
        ntk++;
        tests++;
        if (reg_mode !== 2'b11 || col_en !== 7'b0) begin
          fails++;
          $display("FAIL load_mode got %b exp 11", reg_mode);
        end
      end
    end
    tests++;
    if (ntk != 1) begin
      fails++;
      $display("FAIL load_ticks got %0d exp 1", ntk);
    end
  endtask

  task automatic test_off();
    int k = 0;
    {ch1, ch0} = 2'b10;
    while (!(m_st == 2 && m_pos == 10) && k < 4 * FRAME) begin
      @(negedge clk); k++;
    end
    {ch1, ch0} = 2'b00;
    k = 0;
    while (m_st != 0 && k < 2 * FRAME) begin
      @(negedge clk); k++;
      tests++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL off_finish got %h exp %h", obs, expv());
      end
    end
    for (int t = 0; t < 3 * FRAME; t++) begin
      @(negedge clk);
      tests++;
      if (col_en !== 7'b0 || reg_tick !== 1'b0) begin
        fails++;
        $display("FAIL off_dark got en=%b tick=%b exp 0/0", col_en, reg_tick);
      end
    end
    {ch1, ch0} = 2'b10;
    k = 0;
    while (col_en === 7'b0 && k < 8) begin
      @(negedge clk); k++;
    end
    tests++;
    if (col_sel !== 3'd0 || col_en !== 7'b0000001) begin
      fails++;
      $display("FAIL off_restart got sel=%0d en=%b exp 0/0000001", col_sel, col_en);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    while (!(m_st == 2 && m_pos == 5 * DIV + 2) && k < 2 * FRAME) begin
      @(negedge clk); k++;
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (obs !== 14'h0 || m_st != 0) begin
      fails++;
      $display("FAIL reset_mid got %h exp 0", obs);
    end
    rst = 1'b0;
    k = 0;
    while (col_en === 7'b0 && k < 8) begin
      @(negedge clk); k++;
    end
    tests++;
    if (col_sel !== 3'd0 || col_en !== 7'b0000001) begin
      fails++;
      $display("FAIL reset_resume got sel=%0d en=%b exp 0/0000001", col_sel, col_en);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk);
      tests++;
      if (obs !== expv()) begin
        fails++;
        $display("FAIL random t=%0d got %h exp %h", t, obs, expv());
      end
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 39) == 0)
        {ch1, ch0} = 2'($urandom_range(0, 3));
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_mode_change();
    test_load();
    test_off();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
